// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the single-byte I2C master:
//   - i2c_state_e : transaction FSM states
//   - Q0..Q3      : quarter-phase indices within one SCL bit-time
//   - I2C_WR/I2C_RD : R/W bit values on the bus
//   - ACK/NACK    : acknowledge bit values on the bus
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_RW,
        ST_AACK,
        ST_WDATA,
        ST_RDATA,
        ST_DACK,
        ST_STOP
    } i2c_state_e;

    // Quarter phases of one bit: Q0 SCL low / SDA update, Q1 SCL rises,
    // Q2 SCL high / sample, Q3 SCL falls.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;
    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;

endpackage

// File: rtl/i2c_qtick_gen.sv
// ---------------------------------------------------------------------------
// i2c_qtick_gen
// Quarter-period tick generator. While en is high, qtick pulses once every
// CLK_DIV clk cycles (on the last cycle of each quarter) and quarter holds
// the index of the quarter currently in progress. Dropping en clears both
// counters so the next enable starts cleanly at the beginning of Q0.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   en      in  count enable (block busy)
//   qtick   out 1-cycle pulse on the last clk of each quarter
//   quarter out 2-bit index of the current quarter (Q0..Q3)
// ---------------------------------------------------------------------------
module i2c_qtick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       qtick,
    output logic [1:0] quarter
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    quarter_q, quarter_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quarter_q <= 2'd0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

    always_comb begin
        qtick     = en && (cnt_q == CNT_MAX);
        cnt_d     = cnt_q;
        quarter_d = quarter_q;
        if (!en) begin
            cnt_d     = '0;
            quarter_d = 2'd0;
        end else if (qtick) begin
            cnt_d     = '0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            cnt_d     = cnt_q + CW'(1);
        end
    end

    assign quarter = quarter_q;

endmodule

// File: rtl/i2c_master_byte.sv
// ---------------------------------------------------------------------------
// i2c_master_byte
// Single-byte I2C bus master. One command (7-bit address, R/W, write byte)
// produces START, address+RW, address ACK, one data byte, data ACK/NACK and
// STOP. The read byte and an ACK-error flag are returned to the controller.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cmd_valid/ready  command handshake (ready only while idle)
//   cmd_addr/rd/wdata command fields, latched on accept
//   rd_data          byte from the last successful read
//   done             1-cycle pulse once STOP has completed
//   ack_err          NACK seen on address or write data in last transaction
//   scl              push-pull bus clock, idles high
//   sda              open-drain data: drives 0 or Z only
// ---------------------------------------------------------------------------
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rd,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    i2c_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       rd_q, rd_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ack_err_q, ack_err_d;
    logic       done_q, done_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;
    logic       sda_meta_q, sda_sync_q;

    logic       qtick;
    logic [1:0] quarter;
    logic       sample_tick;
    logic       bit_end_tick;
    logic       sda_in;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_q != ST_IDLE),
        .qtick   (qtick),
        .quarter (quarter)
    );

    // Sampling happens late in Q2, long after SDA settled, so the two-flop
    // synchroniser latency is harmless.
    assign sda_in       = sda_sync_q;
    assign sample_tick  = qtick && (quarter == Q2);
    assign bit_end_tick = qtick && (quarter == Q3);

    // Held off during the done cycle so a back-to-back request is taken
    // only on the cycle after done.
    assign cmd_ready = (state_q == ST_IDLE) && !done_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            rd_q       <= 1'b0;
            wdata_q    <= 8'h00;
            rd_data_q  <= 8'h00;
            ack_err_q  <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            ack_err_q  <= ack_err_d;
            done_q     <= done_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
        end
    end

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rd_d      = rd_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d   = ST_START;
                    shift_d   = {cmd_addr, cmd_rd};
                    rd_d      = cmd_rd;
                    wdata_d   = cmd_wdata;
                    ack_err_d = 1'b0;
                    bit_cnt_d = 3'd7;
                end
            end
            ST_START: begin
                if (bit_end_tick) state_d = ST_ADDR;
            end
            // Counter values 7..1 are address bits; 0 is the RW bit, which
            // sits in shift_q[7] after seven shifts.
            ST_ADDR: begin
                if (bit_end_tick) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd1) state_d = ST_RW;
                end
            end
            ST_RW: begin
                if (bit_end_tick) state_d = ST_AACK;
            end
            ST_AACK: begin
                if (sample_tick && (sda_in != ACK)) ack_err_d = 1'b1;
                if (bit_end_tick) begin
                    bit_cnt_d = 3'd7;
                    if (ack_err_q) begin
                        state_d = ST_STOP;
                    end else if (rd_q == I2C_WR) begin
                        state_d = ST_WDATA;
                        shift_d = wdata_q;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (bit_end_tick) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) state_d = ST_DACK;
                end
            end
            ST_RDATA: begin
                if (sample_tick) shift_d = {shift_q[6:0], sda_in};
                if (bit_end_tick) begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) state_d = ST_DACK;
                end
            end
            ST_DACK: begin
                if (sample_tick) begin
                    if (rd_q == I2C_RD) rd_data_d = shift_q;
                    else if (sda_in == NACK) ack_err_d = 1'b1;
                end
                if (bit_end_tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end_tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- bus output decode ----------------
    // Decoded from the current state/quarter and registered, so the pins
    // are glitch-free and lag the FSM by one clk uniformly.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_q)
            ST_START: begin
                scl_d    = (quarter != Q3);
                sda_oe_d = (quarter == Q2) || (quarter == Q3);
            end
            ST_ADDR, ST_RW, ST_WDATA: begin
                scl_d    = (quarter == Q1) || (quarter == Q2);
                sda_oe_d = !shift_q[7];
            end
            ST_AACK, ST_RDATA, ST_DACK: begin
                scl_d    = (quarter == Q1) || (quarter == Q2);
                sda_oe_d = 1'b0;
            end
            ST_STOP: begin
                scl_d    = (quarter != Q0);
                sda_oe_d = (quarter == Q0) || (quarter == Q1);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    assign scl     = scl_q;
    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign rd_data = rd_data_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_byte
// Drives commands into i2c_master_byte against a behavioural I2C slave
// (address 7'h2A) on a pulled-up SDA line. A transaction-level model
// predicts each result at accept time and queues it; a monitor pops and
// compares on every done pulse, and also checks SCL timing and START/STOP
// counts over the whole run.
// ---------------------------------------------------------------------------
module tb_i2c_master_byte;

    localparam int CLK_DIV = 4;
    localparam logic [6:0] MY_ADDR = 7'h2A;
    localparam int FULL_LEN = 80 * CLK_DIV;
    localparam int NACK_LEN = 44 * CLK_DIV;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rd;
    logic [7:0] cmd_wdata;
    logic [7:0] rd_data;
    logic       done;
    logic       ack_err;
    logic       scl;
    wire        sda_w;

    logic       slv_low = 1'b0;
    pullup (sda_w);
    assign sda_w = slv_low ? 1'b0 : 1'bz;

    i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rd    (cmd_rd),
        .cmd_wdata (cmd_wdata),
        .rd_data   (rd_data),
        .done      (done),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda       (sda_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural slave ----------------
    typedef enum {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK, S_WAIT} sph_e;
    sph_e       sph = S_IDLE;
    logic [7:0] slv_mem = 8'h00;
    logic [7:0] slv_sh = 8'h00;
    logic       slv_rw = 1'b0;
    int         slv_cnt = 0;
    int         slv_sent = 0;
    logic       s_scl = 1'b1, s_sda = 1'b1;
    logic       nack_wr = 1'b0;
    logic [7:0] preset_val = 8'h00;
    int         preset_seq = 0;
    int         preset_done = 0;

    always @(negedge clk) begin
        if (preset_seq != preset_done) begin
            slv_mem     <= preset_val;
            preset_done <= preset_seq;
        end
        if (scl && s_scl && s_sda && !sda_w) begin
            sph <= S_ADDR; slv_cnt <= 0; slv_low <= 1'b0;
        end else if (scl && s_scl && !s_sda && sda_w) begin
            sph <= S_IDLE; slv_low <= 1'b0;
        end else if (scl && !s_scl) begin
            if (sph == S_ADDR || sph == S_WR) begin
                slv_sh  <= {slv_sh[6:0], sda_w};
                slv_cnt <= slv_cnt + 1;
            end
        end else if (!scl && s_scl) begin
            case (sph)
                S_ADDR: if (slv_cnt == 8) begin
                    if (slv_sh[7:1] == MY_ADDR) begin
                        slv_low <= 1'b1; slv_rw <= slv_sh[0]; sph <= S_AACK;
                    end else sph <= S_WAIT;
                end
                S_AACK: begin
                    if (slv_rw) begin
                        slv_low <= !slv_mem[7]; slv_sent <= 1; sph <= S_RD;
                    end else begin
                        slv_low <= 1'b0; slv_cnt <= 0; sph <= S_WR;
                    end
                end
                S_WR: if (slv_cnt == 8) begin
                    if (!nack_wr) begin slv_mem <= slv_sh; slv_low <= 1'b1; end
                    sph <= S_WACK;
                end
                S_WACK: begin slv_low <= 1'b0; sph <= S_WAIT; end
                S_RD: begin
                    if (slv_sent == 8) begin slv_low <= 1'b0; sph <= S_RACK; end
                    else begin slv_low <= !slv_mem[7 - slv_sent]; slv_sent <= slv_sent + 1; end
                end
                S_RACK: begin slv_mem <= 8'h44; sph <= S_WAIT; end
                default: ;
            endcase
        end
        s_scl <= scl;
        s_sda <= sda_w;
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [6:0] addr;
        logic       rd;
        logic       ack_err;
        logic [7:0] rd_data;
        logic [7:0] slave;
        int         len;
        int         rises;
        int         acc_edge;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] ref_slave = 8'h00;
    logic [7:0] ref_rd = 8'h00;
    int last_hs = 0;
    int last_acc = 0;
    int last_done = -10;

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w, input logic hold);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        cmd_addr = a; cmd_rd = r; cmd_wdata = w; cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 5000);
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        last_hs  = cyc;
        last_acc = cyc + 1;
        e.addr = a; e.rd = r; e.acc_edge = cyc + 1;
        if (a != MY_ADDR) begin
            e.ack_err = 1'b1; e.len = NACK_LEN; e.rises = 10;
        end else if (r) begin
            e.ack_err = 1'b0; e.len = FULL_LEN; e.rises = 19;
            ref_rd = ref_slave; ref_slave = 8'h44;
        end else begin
            e.ack_err = nack_wr; e.len = FULL_LEN; e.rises = 19;
            if (!nack_wr) ref_slave = w;
        end
        e.rd_data = ref_rd;
        e.slave   = ref_slave;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- monitor / protocol checker ----------------
    logic m_scl = 1'b1, m_sda = 1'b1;
    logic hi_ok = 1'b0, lo_ok = 1'b0, prev_done = 1'b0;
    int   run_len = 0, rises = 0, starts = 0, stops = 0, txn_n = 0;
    exp_t me;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_ok = 1'b0; lo_ok = 1'b0; run_len = 0;
            rises = 0; starts = 0; stops = 0; prev_done = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin rises = 0; starts = 0; stops = 0; end
            if (scl && m_scl && m_sda && !sda_w) begin starts++; hi_ok = 1'b0; end
            if (scl && m_scl && !m_sda && sda_w) begin stops++; hi_ok = 1'b0; end
            if (scl != m_scl) begin
                if (scl) begin
                    rises++;
                    if (lo_ok) check("scl_low_time", run_len, 2 * CLK_DIV);
                    hi_ok = 1'b1;
                end else begin
                    if (hi_ok) check("scl_high_time", run_len, 2 * CLK_DIV);
                    lo_ok = 1'b1;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            if (done) begin
                check("done_pulse_width", prev_done, 0);
                check("ready_low_in_done", cmd_ready, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    txn_n++;
                    $display("txn %0d: addr=%02h rd=%0b ack_err=%0b rd_data=%02h slave=%02h latency=%0d",
                             txn_n, me.addr, me.rd, ack_err, rd_data, slv_mem, cyc - me.acc_edge);
                    check("latency", cyc - me.acc_edge, me.len);
                    check("ack_err", ack_err, me.ack_err);
                    check("rd_data", rd_data, me.rd_data);
                    check("slave_data", slv_mem, me.slave);
                    check("scl_rises", rises, me.rises);
                    check("start_count", starts, 1);
                    check("stop_count", stops, 1);
                end
                last_done = cyc;
            end
            prev_done = done;
        end
        m_scl = scl;
        m_sda = sda_w;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_rd = 1'b0; cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda_w, 1);
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rd_data", rd_data, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;

        // write 0x5A to the slave
        issue(MY_ADDR, 1'b0, 8'h5A, 1'b0); wait_idle();

        // read back a preset byte
        preset_val = 8'h12; preset_seq++; ref_slave = 8'h12;
        repeat (2) @(negedge clk);
        issue(MY_ADDR, 1'b1, 8'h00, 1'b0); wait_idle();

        // wrong address: NACK, short transaction
        issue(7'h15, 1'b0, 8'hC3, 1'b0); wait_idle();

        // valid held high across a transaction: second accept right after done
        issue(MY_ADDR, 1'b0, 8'hA5, 1'b1);
        issue(MY_ADDR, 1'b1, 8'h00, 1'b0);
        check("back_to_back_accept", last_hs, last_done + 1);
        wait_idle();

        // reset in the middle of the address phase
        issue(7'h00, 1'b0, 8'hFF, 1'b0);
        while (cyc < last_acc + 82) @(negedge clk);
        check("pre_abort_scl", scl, 0);
        check("pre_abort_sda", sda_w, 0);
        rst_n = 1'b0;
        #1;
        check("abort_scl", scl, 1);
        check("abort_sda", sda_w, 1);
        exp_q.delete();
        ref_rd = 8'h00;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_ready", cmd_ready, 1);
        check("post_abort_ack_err", ack_err, 0);
        check("post_abort_rd_data", rd_data, 8'h00);
        repeat (4) @(negedge clk);

        // randomized transactions
        for (int i = 0; i < 16; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) != 0) ? MY_ADDR : 7'($urandom_range(0, 127));
            if (a == MY_ADDR && $urandom_range(0, 7) == 0) a = 7'h2B;
            nack_wr = ($urandom_range(0, 5) == 0);
            issue(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
            wait_idle();
        end

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
